mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters: the IF stage (instruction fetch) and the MEM stage (LW/SW).
- Grants one requester at a time and issues a one-cycle memory command.
- Waits the fixed memory latency, then returns read data with a one-cycle ack.
- Drives stall outputs that the pipeline control logic uses to freeze IF or hold MEM.

---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single-ported unified instruction/data memory between the IF
// stage (instruction fetch) and the MEM stage (LW/SW). One requester is
// granted at a time. The arbiter issues a one-cycle memory command, waits
// the fixed memory latency for reads, and then returns a one-cycle ack.
//
// Request/ack handshake (both requesters):
//   A requester raises *_req and holds it, with stable address and data,
//   until it sees *_ack high for one cycle. The transaction is complete in
//   that ack cycle, and read data (*_rdata) is valid alongside the ack.
//   If req drops before the ack, the transaction still completes and acks.
//   A req that is still high in its own ack cycle is not treated as a new
//   request until the following cycle.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   if_req/if_addr      fetch request and address
//   if_rdata/if_ack     fetched word and completion pulse
//   dm_req/dm_we/...    data request (dm_we=1 store, 0 load), addr, wdata
//   dm_rdata/dm_ack     load data and completion pulse
//   mem_en/mem_we/...   memory command strobe, write enable, addr, wdata
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_dm   combinational stalls: req & ~ack
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic [1:0]        dbg_state
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $fatal(1, "mem_port_arbiter: MEM_LAT must be at least 1");
  end

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    G_IF = 1'b0,
    G_DM = 1'b1
  } grant_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  grant_t             cur, cur_n;          // owner of the in-flight access
  logic               cur_we, cur_we_n;    // store flag latched at grant
  grant_t             last_grant, last_grant_n;
  logic               mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [DATA_W-1:0]  mem_wdata_n;
  logic               if_ack_n, dm_ack_n;
  logic [DATA_W-1:0]  if_rdata_n, dm_rdata_n;

  logic               if_pend, dm_pend;
  logic               grant_if, grant_dm;

  // A req that is being acked this cycle is the one just served, not a
  // new request, so it is masked out of arbitration.
  assign if_pend = if_req & ~if_ack;
  assign dm_pend = dm_req & ~dm_ack;

  // Under contention DM wins unless it won last time, so grants alternate.
  assign grant_dm = dm_pend & (~if_pend | (last_grant == G_IF));
  assign grant_if = if_pend & ~grant_dm;

  assign stall_if  = if_req & ~if_ack;
  assign stall_dm  = dm_req & ~dm_ack;
  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cur_n        = cur;
    cur_we_n     = cur_we;
    last_grant_n = last_grant;
    mem_en_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    if_ack_n     = 1'b0;
    dm_ack_n     = 1'b0;
    if_rdata_n   = if_rdata;
    dm_rdata_n   = dm_rdata;

    case (state)
      // DONE shares the arbitration path with IDLE so a new grant can
      // follow an ack with no idle cycle in between.
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (grant_dm) begin
          state_n      = S_ISSUE;
          mem_en_n     = 1'b1;
          mem_we_n     = dm_we;
          mem_addr_n   = dm_addr;
          mem_wdata_n  = dm_wdata;
          cur_n        = G_DM;
          cur_we_n     = dm_we;
          last_grant_n = G_DM;
        end else if (grant_if) begin
          state_n      = S_ISSUE;
          mem_en_n     = 1'b1;
          mem_addr_n   = if_addr;
          cur_n        = G_IF;
          cur_we_n     = 1'b0;
          last_grant_n = G_IF;
        end
      end

      S_ISSUE: begin
        if ((cur == G_DM) && cur_we) begin
          // Stores need no read-back; ack right away.
          state_n  = S_DONE;
          dm_ack_n = 1'b1;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(MEM_LAT - 1);
        end
      end

      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_DONE;
          if (cur == G_DM) begin
            dm_rdata_n = mem_rdata;
            dm_ack_n   = 1'b1;
          end else begin
            if_rdata_n = mem_rdata;
            if_ack_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur        <= G_IF;
      cur_we     <= 1'b0;
      last_grant <= G_IF;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cur        <= cur_n;
      cur_we     <= cur_we_n;
      last_grant <= last_grant_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_ack     <= if_ack_n;
      dm_ack     <= dm_ack_n;
      if_rdata   <= if_rdata_n;
      dm_rdata   <= dm_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors on a MEM_LAT=2 instance
// (dut_a) and a MEM_LAT=4 instance (dut_b). Each instance has a small
// memory model that drives valid data only in the exact cycle MEM_LAT
// after a command, and a poison word in every other cycle.

module tb_mem_port_arbiter;

  localparam logic [31:0] POISON = 32'hDEAD_0BAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut_a signals (MEM_LAT=2) ----------------
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic [31:0] a_mem_rdata = POISON;
  logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall_if, a_stall_dm;
  logic [1:0]  a_dbg_state;

  // ---------------- dut_b signals (MEM_LAT=4) ----------------
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = POISON;
  logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall_if, b_stall_dm;
  logic [1:0]  b_dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall_if(a_stall_if), .stall_dm(a_stall_dm),
    .dbg_state(a_dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_dm(b_stall_dm),
    .dbg_state(b_dbg_state)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return 32'hA5A5_0000 | {16'h0, a[15:0]};
  endfunction

  // History entry k holds the command seen k cycles ago; data for a
  // command in cycle c is driven during cycle c+MEM_LAT only.
  bit          a_h_en [2];
  logic [31:0] a_h_ad [2];
  always @(posedge clk) begin
    a_h_en[1] = a_h_en[0];
    a_h_ad[1] = a_h_ad[0];
    a_h_en[0] = a_mem_en;
    a_h_ad[0] = a_mem_addr;
    a_mem_rdata <= a_h_en[1] ? mem_word(a_h_ad[1]) : POISON;
  end

  bit          b_h_en [4];
  logic [31:0] b_h_ad [4];
  always @(posedge clk) begin
    for (int i = 3; i > 0; i--) begin
      b_h_en[i] = b_h_en[i-1];
      b_h_ad[i] = b_h_ad[i-1];
    end
    b_h_en[0] = b_mem_en;
    b_h_ad[0] = b_mem_addr;
    b_mem_rdata <= b_h_en[3] ? mem_word(b_h_ad[3]) : POISON;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " mem_en"},    a_mem_en,    0);
    check({tag, " mem_we"},    a_mem_we,    0);
    check({tag, " mem_addr"},  a_mem_addr,  0);
    check({tag, " mem_wdata"}, a_mem_wdata, 0);
    check({tag, " if_ack"},    a_if_ack,    0);
    check({tag, " dm_ack"},    a_dm_ack,    0);
    check({tag, " if_rdata"},  a_if_rdata,  0);
    check({tag, " dm_rdata"},  a_dm_rdata,  0);
    check({tag, " state"},     a_dbg_state, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic en_prev;
    logic en_back2back;

    // T1: single IF read, MEM_LAT=2
    do_reset();
    check_a_zero("t1 reset");
    a_if_req = 1; a_if_addr = 32'h40;
    #1;
    check("t1 stall_if c0", a_stall_if, 1);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      check($sformatf("t1 mem_en c%0d", c), a_mem_en, (c == 1));
      check($sformatf("t1 if_ack c%0d", c), a_if_ack, (c == 4));
      check($sformatf("t1 stall_if c%0d", c), a_stall_if, (c < 4));
      if (c == 1) begin
        check("t1 mem_addr", a_mem_addr, 32'h40);
        check("t1 mem_we", a_mem_we, 0);
      end
      if (c == 4) begin
        check("t1 if_rdata", a_if_rdata, 32'h8C22_0004);
        a_if_req = 0;
      end
    end

    // T2: single store, ack independent of latency
    do_reset();
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h100; a_dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      check($sformatf("t2 mem_en c%0d", c), a_mem_en, (c == 1));
      check($sformatf("t2 dm_ack c%0d", c), a_dm_ack, (c == 2));
      if (c == 1) begin
        check("t2 mem_we", a_mem_we, 1);
        check("t2 mem_addr", a_mem_addr, 32'h100);
        check("t2 mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
      end
      if (c == 2) begin
        check("t2 dm_rdata kept", a_dm_rdata, 0);
        a_dm_req = 0;
      end
    end

    // T3: contention from reset, DM first
    do_reset();
    a_if_req = 1; a_if_addr = 32'h80;
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h200;
    exp_q.push_back(mem_word(32'h200));
    exp_q.push_back(mem_word(32'h80));
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      check($sformatf("t3 dm_ack c%0d", c), a_dm_ack, (c == 4));
      check($sformatf("t3 if_ack c%0d", c), a_if_ack, (c == 8));
      check($sformatf("t3 mem_en c%0d", c), a_mem_en, (c == 1 || c == 5));
      check($sformatf("t3 stall_if c%0d", c), a_stall_if, (c < 8));
      if (c == 1) check("t3 mem_addr dm", a_mem_addr, 32'h200);
      if (c == 5) begin
        check("t3 mem_addr if", a_mem_addr, 32'h80);
        check("t3 mem_we if", a_mem_we, 0);
      end
      if (c == 4) begin
        check("t3 dm_rdata", a_dm_rdata, exp_q.pop_front());
        a_dm_req = 0;
      end
      if (c == 8) begin
        check("t3 if_rdata", a_if_rdata, exp_q.pop_front());
        a_if_req = 0;
      end
    end

    // T4: both requesters keep requesting, grants alternate
    do_reset();
    a_if_req = 1; a_if_addr = 32'h300;
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h400;
    en_prev = 0;
    en_back2back = 0;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (en_prev && a_mem_en) en_back2back = 1;
      en_prev = a_mem_en;
      check($sformatf("t4 mem_en c%0d", c), a_mem_en, (c % 4 == 1));
      check($sformatf("t4 dm_ack c%0d", c), a_dm_ack, (c == 4 || c == 12));
      check($sformatf("t4 if_ack c%0d", c), a_if_ack, (c == 8 || c == 16));
      if (c % 4 == 1)
        check($sformatf("t4 grant addr c%0d", c), a_mem_addr, (c % 8 == 1) ? 32'h400 : 32'h300);
    end
    check("t4 no back-to-back mem_en", en_back2back, 0);
    a_if_req = 0; a_dm_req = 0;

    // T5: reset during an IF read
    do_reset();
    a_if_req = 1; a_if_addr = 32'h40;
    next_cycle();  // c1
    next_cycle();  // c2
    rst = 1;
    next_cycle();  // c3
    rst = 0;
    check_a_zero("t5 after reset");
    for (int c = 4; c <= 8; c++) begin
      next_cycle();
      check($sformatf("t5 mem_en c%0d", c), a_mem_en, (c == 4));
      check($sformatf("t5 if_ack c%0d", c), a_if_ack, (c == 7));
      if (c == 7) begin
        check("t5 if_rdata", a_if_rdata, 32'h8C22_0004);
        a_if_req = 0;
      end
    end

    // T6: IF drops req early; transaction still completes
    do_reset();
    a_if_req = 1; a_if_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) a_if_req = 0;
      check($sformatf("t6 if_ack c%0d", c), a_if_ack, (c == 4));
    end

    // T7: MEM_LAT=4 load
    do_reset();
    b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h500;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      check($sformatf("t7 mem_en c%0d", c), b_mem_en, (c == 1));
      check($sformatf("t7 dm_ack c%0d", c), b_dm_ack, (c == 6));
      check($sformatf("t7 stall_dm c%0d", c), b_stall_dm, (c < 6));
      if (c == 6) begin
        check("t7 dm_rdata", b_dm_rdata, mem_word(32'h500));
        b_dm_req = 0;
      end
    end

    // T8: MEM_LAT=4 store acks after two cycles
    do_reset();
    b_dm_req = 1; b_dm_we = 1; b_dm_addr = 32'h600; b_dm_wdata = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      check($sformatf("t8 dm_ack c%0d", c), b_dm_ack, (c == 2));
      if (c == 1) check("t8 mem_wdata", b_mem_wdata, 32'h1234_5678);
      if (c == 2) b_dm_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
